led_arbiter: RTL
================

LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the LED bank.
REQ-002 Parameter BITS, default 4: LED pattern width.
REQ-003 Parameter LOG2HOLD, default 22: grant hold slot is 2^LOG2HOLD clk cycles (~70 ms at 60 MHz).
REQ-004 clk  input  1  single system clock (60 MHz external); all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N_REQ  per-requester LED ownership request, level-sensitive.
REQ-007 data  input  N_REQ*BITS  per-requester pattern; requester i occupies bits [i*BITS +: BITS].
REQ-008 grant  output  N_REQ  one-hot current owner, all-zero when idle.
REQ-009 busy  output  1  high while any requester owns the LEDs.
REQ-010 LED2, LED3, LED4, LED5  output  1 each  {LED2,LED3,LED4,LED5} = registered pattern of owner, MSB on LED2.

Function
REQ-011 FSM states: IDLE (no owner), OWN (one owner, hold counter running).
REQ-012 IDLE: any req bit high -> OWN next cycle; winner is first asserted index at or after rr_ptr, searching upward with wrap at N_REQ-1 -> 0.
REQ-013 Entering OWN: hold counter cleared to 0; grant one-hot for winner; rr_ptr <= winner+1 mod N_REQ.
REQ-014 OWN: hold counter increments by 1 each cycle, LOG2HOLD bits wide, expiry when counter == 2^LOG2HOLD-1.
REQ-015 OWN, owner's req drops: release on next cycle (early release); re-arbitrate from rr_ptr that same cycle; if no req, go IDLE.
REQ-016 OWN, expiry with another req pending: hand over to next requester from rr_ptr, counter restarts; no idle cycle between owners.
REQ-017 OWN, expiry with only owner requesting: owner retains grant, counter restarts at 0.
REQ-018 Expiry and owner req-drop in same cycle: treated as req-drop (REQ-015).
REQ-019 LED outputs register data slice of grant owner each cycle: latency 1 cycle from grant change, owner data changes follow with 1-cycle latency.
REQ-020 In IDLE, LED2..LED5 driven 0 one cycle after grant goes zero.
REQ-021 busy == |grant, both registered; grant never has more than one bit set.
REQ-022 req changes of non-owners never affect current grant before expiry.

Reset
REQ-023 On rst high, asynchronously: state IDLE, grant 0, busy 0, LED2..LED5 0, hold counter 0, rr_ptr 0.
REQ-024 rst asserted mid-OWN aborts ownership; after rst deassert, arbitration restarts from index 0.
REQ-025 First arbitration possible on the first posedge clk after rst deassert.

Structure
REQ-026 Shared package holds BITS, N_REQ defaults, LOG2HOLD default and state encodings (IDLE=0, OWN=1).
REQ-027 Round-robin priority search (req, rr_ptr -> one-hot winner, valid) is a sub-module named led_rr_pick; hold counter and LED register stay in led_arbiter.

Verification (LOG2HOLD=4, slot 16 cycles, N_REQ=4, BITS=4)
REQ-028 rst high, req=4'b1111 -> grant=0, busy=0, LEDs=0 while rst high; after release, grant=4'b0001 next edge, LEDs=data[3:0] one edge later.
REQ-029 req=4'b0101, data0=4'hA, data2=4'h5 held -> grant alternates 0001/0100 every 16 cycles, LEDs alternate A/5, no idle cycle.
REQ-030 req=4'b0010 only, held 64 cycles -> grant stays 0010 throughout, counter wraps 4 times, LEDs stable.
REQ-031 owner 0001 drops req at cycle 5 of slot, req[3] high -> grant=1000 next cycle, LEDs=data3 one cycle later.
REQ-032 req[0] drop coincident with expiry, no other req -> IDLE, grant=0, busy=0, LEDs=0 one cycle later.
REQ-033 rst pulsed mid-slot while grant=0100 -> outputs 0 immediately (no clk edge), then grant=0001 if req[0] high after release.

Source files
------------

// File: rtl/led_arbiter_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the LED bank arbiter.
package led_arbiter_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int BITS_DEF     = 4;
    localparam int LOG2HOLD_DEF = 22;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Round-robin priority search: first asserted request at or after rr_ptr, wrapping.
module led_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] winner_idx,
    output logic             valid
);

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            logic [31:0]      pos;
            logic [PTR_W-1:0] pos_w;
            pos   = (32'(rr_ptr) + i) % N_REQ;
            pos_w = PTR_W'(pos);
            if (!valid && req[pos_w]) begin
                valid         = 1'b1;
                winner[pos_w] = 1'b1;
                winner_idx    = pos_w;
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Time-sliced round-robin arbiter granting one requester at a time ownership of a 4-LED bank.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int BITS     = BITS_DEF,
    parameter int LOG2HOLD = LOG2HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*BITS-1:0] data,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic                  LED2,
    output logic                  LED3,
    output logic                  LED4,
    output logic                  LED5
);

    localparam int PTR_W = ptr_width(N_REQ);

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [LOG2HOLD-1:0] hold_q, hold_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BITS-1:0]     led_q, led_d;

    logic [N_REQ-1:0]    pick_oh;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                owner_req;
    logic                expiry;
    logic                rearb;

    led_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // Early release and expiry share one re-arbitration path; searching from
    // rr_ptr (owner+1) visits the owner last, so it keeps the grant only when alone.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        rr_ptr_d  = rr_ptr_q;
        owner_req = |(req & grant_q);
        expiry    = &hold_q;
        rearb     = (state_q == IDLE) || !owner_req || expiry;

        if (rearb) begin
            hold_d = '0;
            if (pick_valid) begin
                state_d  = OWN;
                grant_d  = pick_oh;
                rr_ptr_d = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end else begin
            hold_d = hold_q + LOG2HOLD'(1);
        end

        busy_d = |grant_d;

        led_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                led_d = led_d | data[i*BITS +: BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            hold_q   <= '0;
            rr_ptr_q <= '0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
            led_q    <= led_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign LED2  = led_q[BITS-1];
    assign LED3  = led_q[BITS-2];
    assign LED4  = led_q[BITS-3];
    assign LED5  = led_q[BITS-4];

endmodule
